param_bank: RTL and testbench

- Parametrised bank of NUM_REGS signed fixed-point parameter registers for the Mode7 renderer: offsets, origins, texture size, scales and angle.
- A selector index picks one register. Debounced plus/minus levels step that register, with press-and-hold auto-repeat, fine/coarse step, per-register saturate-or-wrap arithmetic and a restore-default command.
- Sits between the debounce stage and the Mode7 transform datapath. Replaces the fixed 9x24 manager and its slow-clock update domain with a single-clock design.

---
 rtl/mode7_pkg.sv | 41 ++++
 rtl/param_step_ctrl.sv | 103 ++++++++++
 rtl/param_bank.sv | 116 +++++++++++
 tb/tb_param_bank.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mode7_pkg.sv
// Shared constants for the Mode7 parameter bank: register indices,
// default register contents, wrap mask and the step-controller states.
package mode7_pkg;

  localparam int unsigned IDX_OFFSETX  = 0;
  localparam int unsigned IDX_OFFSETY  = 1;
  localparam int unsigned IDX_ORIGINX  = 2;
  localparam int unsigned IDX_ORIGINY  = 3;
  localparam int unsigned IDX_TEXTUREW = 4;
  localparam int unsigned IDX_TEXTUREH = 5;
  localparam int unsigned IDX_SCALEX   = 6;
  localparam int unsigned IDX_SCALEY   = 7;
  localparam int unsigned IDX_ANGLE    = 8;

  localparam int unsigned M7_NUM_REGS = 9;
  localparam int unsigned M7_WIDTH    = 24;

  // Texture size 64.0, scales 1.0 (8 fraction bits), everything else 0.
  localparam logic [M7_NUM_REGS*M7_WIDTH-1:0] M7_RESET_VALUES = {
    24'h000000,  // angle
    24'h000100,  // scaley
    24'h000100,  // scalex
    24'h004000,  // textureh
    24'h004000,  // texturew
    24'h000000,  // originy
    24'h000000,  // originx
    24'h000000,  // offsety
    24'h000000   // offsetx
  };

  // Only the angle register wraps around; all others saturate.
  localparam logic [M7_NUM_REGS-1:0] M7_WRAP_MASK = 9'h100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT,
    ST_WAIT_REL
  } step_state_e;

endpackage

// File: rtl/param_step_ctrl.sv
// Button step controller: turns held plus/minus levels into single-cycle
// increment/decrement strobes with press-and-hold auto-repeat.
module param_step_ctrl
  import mode7_pkg::*;
#(
  parameter int unsigned SELW          = 4,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SELW-1:0] sel,
  input  logic            sel_valid,
  input  logic            btn_plus,
  input  logic            btn_minus,
  input  logic            restore_fire,
  output logic            step_inc,
  output logic            step_dec
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  step_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            act_plus_q, act_plus_d;
  logic [SELW-1:0] sel_q, sel_d;
  // "Seen low last cycle" flags: reset to 0 so a button held through
  // reset must be released and pressed again before it can step.
  logic            plus_lo_q, minus_lo_q;
  logic            fire, act_lvl, oth_lvl;

  // Next-state and step decision; the strobe is a same-cycle decision so the
  // bank can register the new value and its update pulse on one edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_plus_d = act_plus_q;
    sel_d      = sel_q;
    fire       = 1'b0;
    act_lvl    = act_plus_q ? btn_plus  : btn_minus;
    oth_lvl    = act_plus_q ? btn_minus : btn_plus;
    case (state_q)
      ST_IDLE: begin
        if (btn_plus && btn_minus) begin
          state_d = ST_WAIT_REL;
        end else if ((btn_plus && plus_lo_q) || (btn_minus && minus_lo_q)) begin
          fire       = 1'b1;
          act_plus_d = btn_plus;
          sel_d      = sel;
          cnt_d      = '0;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!act_lvl) begin
          state_d = ST_IDLE;
        end else if (oth_lvl || (sel != sel_q)) begin
          state_d = ST_WAIT_REL;
        end else if (cnt_q == ((state_q == ST_HOLD) ? DELAY_LAST : PERIOD_LAST)) begin
          fire    = 1'b1;
          cnt_d   = '0;
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (!btn_plus && !btn_minus) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A coincident restore wins: drop the step and wait for release.
    if (fire && restore_fire) begin
      fire    = 1'b0;
      state_d = ST_WAIT_REL;
    end
    step_inc = fire &  act_plus_d & sel_valid;
    step_dec = fire & ~act_plus_d & sel_valid;
  end

  // State, repeat counter and button history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      act_plus_q <= 1'b0;
      sel_q      <= '0;
      plus_lo_q  <= 1'b0;
      minus_lo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_plus_q <= act_plus_d;
      sel_q      <= sel_d;
      plus_lo_q  <= ~btn_plus;
      minus_lo_q <= ~btn_minus;
    end
  end

endmodule

// File: rtl/param_bank.sv
// Bank of signed fixed-point Mode7 parameters edited one at a time via
// plus/minus buttons, with saturate-or-wrap arithmetic and restore-default.
module param_bank
  import mode7_pkg::*;
#(
  parameter int unsigned                    NUM_REGS      = 9,
  parameter int unsigned                    WIDTH         = 24,
  parameter int unsigned                    FRAC          = 8,
  parameter logic [NUM_REGS*WIDTH-1:0]      RESET_VALUES  = M7_RESET_VALUES,
  parameter logic [NUM_REGS-1:0]            WRAP_MASK     = M7_WRAP_MASK,
  parameter int unsigned                    REPEAT_DELAY  = 25_000_000,
  parameter int unsigned                    REPEAT_PERIOD = 5_000_000,
  parameter int unsigned                    SELW          = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SELW-1:0]           sel,
  input  logic                      btn_plus,
  input  logic                      btn_minus,
  input  logic                      fine,
  input  logic                      restore,
  output logic [NUM_REGS*WIDTH-1:0] values,
  output logic                      upd_valid,
  output logic [SELW-1:0]           upd_idx,
  output logic                      sel_err
);

  localparam logic [WIDTH:0]   FINE_STEP   = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   COARSE_STEP = (WIDTH+1)'(1) << FRAC;
  localparam logic [WIDTH-1:0] SAT_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN     = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] val_q [NUM_REGS];
  logic [WIDTH-1:0] def_val [NUM_REGS];
  logic             restore_q;
  logic             upd_valid_q;
  logic [SELW-1:0]  upd_idx_q;
  logic             sel_err_q;

  logic             sel_valid, restore_fire, step_inc, step_dec;
  logic [SELW-1:0]  sel_idx;
  logic [WIDTH-1:0] cur, nxt;
  logic [WIDTH:0]   cur_ext, step_amt, sum;

  assign sel_valid    = (32'(sel) < NUM_REGS);
  assign sel_idx      = sel_valid ? sel : '0;
  assign restore_fire = restore & ~restore_q & sel_valid;

  param_step_ctrl #(
    .SELW          (SELW),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .sel          (sel),
    .sel_valid    (sel_valid),
    .btn_plus     (btn_plus),
    .btn_minus    (btn_minus),
    .restore_fire (restore_fire),
    .step_inc     (step_inc),
    .step_dec     (step_dec)
  );

  // Unpack defaults and pack the live registers onto the flat output.
  always_comb begin
    values = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      def_val[i]                 = RESET_VALUES[i*WIDTH +: WIDTH];
      values[i*WIDTH +: WIDTH]   = val_q[i];
    end
  end

  // One extra sign bit catches overflow; saturate or keep low bits per register.
  always_comb begin
    cur      = val_q[sel_idx];
    cur_ext  = {cur[WIDTH-1], cur};
    step_amt = fine ? FINE_STEP : COARSE_STEP;
    sum      = step_inc ? (cur_ext + step_amt) : (cur_ext - step_amt);
    nxt      = sum[WIDTH-1:0];
    if (!WRAP_MASK[sel_idx] && (sum[WIDTH] != sum[WIDTH-1])) begin
      nxt = sum[WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  // Register array update: restore first, then a step, only at index sel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= RESET_VALUES[i*WIDTH +: WIDTH];
      end
      restore_q   <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      restore_q   <= restore;
      sel_err_q   <= ~sel_valid;
      upd_valid_q <= 1'b0;
      if (restore_fire) begin
        val_q[sel_idx] <= def_val[sel_idx];
        upd_valid_q    <= 1'b1;
        upd_idx_q      <= sel_idx;
      end else if (step_inc || step_dec) begin
        val_q[sel_idx] <= nxt;
        upd_valid_q    <= 1'b1;
        upd_idx_q      <= sel_idx;
      end
    end
  end

  assign upd_valid = upd_valid_q;
  assign upd_idx   = upd_idx_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_param_bank.sv
// Self-checking bench for param_bank: constant vector table, hand-written
// corner sequences and randomized presses against a step-count model.
module tb_param_bank;

  localparam int D = 8;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   sel;
  logic         btn_plus, btn_minus, fine, restore;
  logic [215:0] vals0, vals1;
  logic         upd_valid0, upd_valid1, sel_err0, sel_err1;
  logic [3:0]   upd_idx0, upd_idx1;

  localparam logic [215:0] SAT_RV = {24'h7FFFFF, 24'h0, 24'h0, 24'h0, 24'h0,
                                     24'h7FFF80, 24'h800000, 24'h7FFFFF, 24'h0};

  param_bank #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
    .clk(clk), .reset(reset), .sel(sel), .btn_plus(btn_plus), .btn_minus(btn_minus),
    .fine(fine), .restore(restore), .values(vals0), .upd_valid(upd_valid0),
    .upd_idx(upd_idx0), .sel_err(sel_err0)
  );

  param_bank #(.RESET_VALUES(SAT_RV), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut_sat (
    .clk(clk), .reset(reset), .sel(sel), .btn_plus(btn_plus), .btn_minus(btn_minus),
    .fine(fine), .restore(restore), .values(vals1), .upd_valid(upd_valid1),
    .upd_idx(upd_idx1), .sel_err(sel_err1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses0, pulses1, idx_bad;
  logic [3:0]  cur_sel;
  logic [23:0] def0 [9];
  logic [23:0] def1 [9];
  logic [23:0] m0 [9];
  logic [23:0] m1 [9];
  logic [8:0]  wmask;

  typedef struct {
    int          s;
    bit          f;
    bit          inc;
    int          hold;
    logic [23:0] exp_val;
    int          exp_pulses;
  } vec_t;
  vec_t vecs [6];

  // Count update pulses and flag any pulse naming the wrong register.
  always @(negedge clk) begin
    if (upd_valid0) begin
      pulses0++;
      if (upd_idx0 != cur_sel) idx_bad++;
    end
    if (upd_valid1) begin
      pulses1++;
      if (upd_idx1 != cur_sel) idx_bad++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference step: plain integer add, then clamp or take modulo 2^24.
  function automatic logic [23:0] mstep(input logic [23:0] v, input bit wrap,
                                        input bit inc, input bit f);
    longint x;
    longint s;
    x = longint'($signed(v));
    s = f ? 64'sd1 : 64'sd256;
    x = inc ? x + s : x - s;
    if (!wrap) begin
      if (x > 64'sd8388607)  x = 64'sd8388607;
      if (x < -64'sd8388608) x = -64'sd8388608;
    end
    return 24'(x);
  endfunction

  task automatic compare_all(input string tag);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("%s dut r%0d", tag, i), 64'(vals0[i*24 +: 24]), 64'(m0[i]));
      chk($sformatf("%s sat r%0d", tag, i), 64'(vals1[i*24 +: 24]), 64'(m1[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      m0[i] = def0[i];
      m1[i] = def1[i];
    end
  endtask

  task automatic clear_counts();
    pulses0 = 0;
    pulses1 = 0;
    idx_bad = 0;
  endtask

  // Hold one button for 'hold' cycles, release for 'rel' cycles, then check.
  task automatic press(input int s, input bit f, input bit inc, input int hold, input int rel);
    int steps;
    bit valid;
    clear_counts();
    sel       = 4'(s);
    cur_sel   = 4'(s);
    fine      = f;
    btn_plus  = inc;
    btn_minus = !inc;
    tick(hold);
    btn_plus  = 1'b0;
    btn_minus = 1'b0;
    tick(rel);
    valid = (s < 9);
    steps = 1 + (((hold - 1) >= D) ? ((hold - 1 - D) / P + 1) : 0);
    if (valid) begin
      for (int k = 0; k < steps; k++) begin
        m0[s] = mstep(m0[s], wmask[s], inc, f);
        m1[s] = mstep(m1[s], wmask[s], inc, f);
      end
    end
    chk($sformatf("pulses dut s%0d h%0d", s, hold), 64'(pulses0), 64'(valid ? steps : 0));
    chk($sformatf("pulses sat s%0d h%0d", s, hold), 64'(pulses1), 64'(valid ? steps : 0));
    chk("upd_idx", 64'(idx_bad), 64'd0);
    compare_all($sformatf("press s%0d", s));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    model_reset();
  endtask

  initial begin
    wmask = 9'h100;
    def0[0] = 24'h0;      def0[1] = 24'h0;      def0[2] = 24'h0;
    def0[3] = 24'h0;      def0[4] = 24'h004000; def0[5] = 24'h004000;
    def0[6] = 24'h000100; def0[7] = 24'h000100; def0[8] = 24'h0;
    def1[0] = 24'h0;      def1[1] = 24'h7FFFFF; def1[2] = 24'h800000;
    def1[3] = 24'h7FFF80; def1[4] = 24'h0;      def1[5] = 24'h0;
    def1[6] = 24'h0;      def1[7] = 24'h0;      def1[8] = 24'h7FFFFF;

    vecs[0] = '{s: 0, f: 1'b0, inc: 1'b1, hold: 2,  exp_val: 24'h000100, exp_pulses: 1};
    vecs[1] = '{s: 6, f: 1'b0, inc: 1'b0, hold: 20, exp_val: 24'hFFFD00, exp_pulses: 4};
    vecs[2] = '{s: 1, f: 1'b0, inc: 1'b1, hold: 1,  exp_val: 24'h000100, exp_pulses: 1};
    vecs[3] = '{s: 2, f: 1'b1, inc: 1'b0, hold: 9,  exp_val: 24'hFFFFFE, exp_pulses: 2};
    vecs[4] = '{s: 3, f: 1'b0, inc: 1'b0, hold: 13, exp_val: 24'hFFFD00, exp_pulses: 3};
    vecs[5] = '{s: 8, f: 1'b1, inc: 1'b1, hold: 12, exp_val: 24'h000002, exp_pulses: 2};

    reset = 1'b1; sel = '0; btn_plus = 1'b0; btn_minus = 1'b0; fine = 1'b0; restore = 1'b0;
    cur_sel = '0;
    clear_counts();
    tick(2);
    reset = 1'b0;
    tick(2);
    model_reset();

    // Reset state
    chk("reset upd_valid", 64'(upd_valid0), 64'd0);
    chk("reset upd_idx", 64'(upd_idx0), 64'd0);
    chk("reset sel_err", 64'(sel_err0), 64'd0);
    chk("reset reg4", 64'(vals0[4*24 +: 24]), 64'h004000);
    chk("reset reg6", 64'(vals0[6*24 +: 24]), 64'h000100);
    compare_all("reset");

    // Constant vector table
    for (int v = 0; v < 6; v++) begin
      press(vecs[v].s, vecs[v].f, vecs[v].inc, vecs[v].hold, 2);
      chk($sformatf("vec%0d value", v), 64'(vals0[vecs[v].s*24 +: 24]), 64'(vecs[v].exp_val));
      chk($sformatf("vec%0d pulses", v), 64'(pulses0), 64'(vecs[v].exp_pulses));
    end

    // Saturation and wrap boundaries on the preloaded instance
    do_reset();
    press(1, 1'b1, 1'b1, 1, 2);
    chk("sat max hold", 64'(vals1[1*24 +: 24]), 64'h7FFFFF);
    chk("sat max pulse", 64'(pulses1), 64'd1);
    press(8, 1'b1, 1'b1, 1, 2);
    chk("wrap up", 64'(vals1[8*24 +: 24]), 64'h800000);
    press(8, 1'b0, 1'b0, 1, 2);
    chk("wrap down", 64'(vals1[8*24 +: 24]), 64'h7FFF00);
    press(2, 1'b0, 1'b0, 1, 2);
    chk("sat min hold", 64'(vals1[2*24 +: 24]), 64'h800000);
    press(3, 1'b0, 1'b1, 1, 2);
    chk("sat partial", 64'(vals1[3*24 +: 24]), 64'h7FFFFF);

    // Both buttons together: no step until both released
    clear_counts();
    sel = 4'd0; cur_sel = 4'd0; fine = 1'b0;
    btn_plus = 1'b1; btn_minus = 1'b1;
    tick(20);
    btn_plus = 1'b0; btn_minus = 1'b0;
    tick(2);
    chk("both pulses", 64'(pulses0), 64'd0);
    compare_all("both");
    press(0, 1'b0, 1'b1, 1, 2);

    // Selector change mid-hold aborts repeat
    clear_counts();
    sel = 4'd0; cur_sel = 4'd0; btn_plus = 1'b1;
    tick(4);
    sel = 4'd1;
    tick(20);
    btn_plus = 1'b0;
    tick(2);
    m0[0] = mstep(m0[0], 1'b0, 1'b1, 1'b0);
    m1[0] = mstep(m1[0], 1'b0, 1'b1, 1'b0);
    chk("selchg pulses", 64'(pulses0), 64'd1);
    compare_all("selchg");

    // Out-of-range selector
    sel = 4'd9;
    tick(1);
    chk("sel_err set", 64'(sel_err0), 64'd1);
    press(9, 1'b0, 1'b1, 5, 2);
    clear_counts();
    sel = 4'd9; restore = 1'b1;
    tick(2);
    restore = 1'b0;
    tick(1);
    chk("restore bad sel", 64'(pulses0), 64'd0);
    sel = 4'd0;
    tick(1);
    chk("sel_err clear", 64'(sel_err0), 64'd0);

    // Restore edge reloads default next cycle
    press(4, 1'b0, 1'b1, 1, 2);
    chk("reg4 modified", 64'(vals0[4*24 +: 24]), 64'h004100);
    clear_counts();
    sel = 4'd4; cur_sel = 4'd4; restore = 1'b1;
    tick(1);
    chk("restore value", 64'(vals0[4*24 +: 24]), 64'h004000);
    chk("restore upd_valid", 64'(upd_valid0), 64'd1);
    chk("restore upd_idx", 64'(upd_idx0), 64'd4);
    restore = 1'b0;
    tick(2);
    chk("restore pulses", 64'(pulses0), 64'd1);
    m0[4] = def0[4]; m1[4] = def1[4];

    // Restore and press in the same cycle: restore wins, no step
    press(5, 1'b0, 1'b0, 1, 2);
    clear_counts();
    sel = 4'd5; cur_sel = 4'd5; restore = 1'b1; btn_plus = 1'b1;
    tick(20);
    btn_plus = 1'b0; restore = 1'b0;
    tick(3);
    m0[5] = def0[5]; m1[5] = def1[5];
    chk("prio value", 64'(vals0[5*24 +: 24]), 64'h004000);
    chk("prio pulses", 64'(pulses0), 64'd1);
    compare_all("prio");

    // Reset asserted mid-repeat with the button still held
    sel = 4'd0; cur_sel = 4'd0; fine = 1'b0; btn_plus = 1'b1;
    tick(14);
    reset = 1'b1;
    #2;
    model_reset();
    chk("async reset reg0", 64'(vals0[0 +: 24]), 64'h0);
    chk("async reset upd", 64'(upd_valid0), 64'd0);
    tick(2);
    reset = 1'b0;
    clear_counts();
    tick(20);
    chk("held after reset", 64'(pulses0), 64'd0);
    compare_all("postreset");
    btn_plus = 1'b0;
    tick(2);
    press(0, 1'b0, 1'b1, 1, 2);

    // Randomized presses against the model
    for (int r = 0; r < 40; r++) begin
      press(int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(1, 22)), int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
